// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_pkg;

  localparam int IRQ_N_DEFAULT = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: reports the lowest set bit index and a valid flag.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N_IRQ   = IRQ_N_DEFAULT,
  parameter int CAUSE_W = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0]   vec_i,
  output logic [CAUSE_W-1:0] idx_o,
  output logic               valid_o
);

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = CAUSE_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: pending/mask registers, lowest-index selection, single-request handshake.
// Optional IRQ_CTRL_EDGE_EN: rising-edge source detection instead of level sensing.
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_IRQ   = IRQ_N_DEFAULT,
  parameter int CAUSE_W = $clog2(N_IRQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_IRQ-1:0]   irq_src_i,
  input  logic               mask_we_i,
  input  logic [N_IRQ-1:0]   mask_wd_i,
  output logic [N_IRQ-1:0]   mask_o,
  output logic [N_IRQ-1:0]   pending_o,
  output logic               irq_req_o,
  output logic [CAUSE_W-1:0] irq_cause_o,
  input  logic               irq_ret_i
);

  logic [N_IRQ-1:0]   r_pending;
  logic [N_IRQ-1:0]   r_mask;
  logic               r_req;
  logic [CAUSE_W-1:0] r_cause;
  irq_state_t         r_state;

  logic [N_IRQ-1:0]   w_event;
  logic [N_IRQ-1:0]   w_clr;
  logic [N_IRQ-1:0]   w_sel;
  logic [CAUSE_W-1:0] w_idx;
  logic               w_valid;

`ifdef IRQ_CTRL_EDGE_EN
  logic [N_IRQ-1:0] r_src_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_src_q <= '0;
    else       r_src_q <= irq_src_i;
  end

  assign w_event = irq_src_i & ~r_src_q;
`else
  assign w_event = irq_src_i;
`endif

  // Selection sees the registered pending/mask, giving the two-cycle event-to-request latency.
  assign w_sel = r_pending & r_mask;

  irq_prio_enc #(
    .N_IRQ   (N_IRQ),
    .CAUSE_W (CAUSE_W)
  ) u_prio_enc (
    .vec_i   (w_sel),
    .idx_o   (w_idx),
    .valid_o (w_valid)
  );

  always_comb begin
    w_clr = '0;
    if (r_state == ACTIVE && irq_ret_i) w_clr[r_cause] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pending <= '0;
      r_mask    <= '0;
      r_req     <= 1'b0;
      r_cause   <= '0;
      r_state   <= IDLE;
    end else begin
      // New events OR in after the clear so a same-cycle retrigger is never lost.
      r_pending <= (r_pending & ~w_clr) | w_event;
      if (mask_we_i) r_mask <= mask_wd_i;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_cause <= w_idx;
            r_req   <= 1'b1;
            r_state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (irq_ret_i) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mask_o      = r_mask;
  assign pending_o   = r_pending;
  assign irq_req_o   = r_req;
  assign irq_cause_o = r_cause;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized traffic against a reference model.
module tb_irq_controller;

  localparam int N = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic [N-1:0]  irq_src_i = '0;
  logic          mask_we_i = 1'b0;
  logic [N-1:0]  mask_wd_i = '0;
  logic [N-1:0]  mask_o;
  logic [N-1:0]  pending_o;
  logic          irq_req_o;
  logic [CW-1:0] irq_cause_o;
  logic          irq_ret_i = 1'b0;

  irq_controller #(.N_IRQ(N), .CAUSE_W(CW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .irq_src_i   (irq_src_i),
    .mask_we_i   (mask_we_i),
    .mask_wd_i   (mask_wd_i),
    .mask_o      (mask_o),
    .pending_o   (pending_o),
    .irq_req_o   (irq_req_o),
    .irq_cause_o (irq_cause_o),
    .irq_ret_i   (irq_ret_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model: a set of pending sources, a mask, and whether a request is outstanding.
  bit [N-1:0] m_pend, m_mask, m_prev_src;
  bit         m_busy;
  int         m_cause;

  function automatic int lowest(input bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    bit [N-1:0] ev, nxt_pend;
    int pick;
    if (rst_i) begin
      m_pend = '0; m_mask = '0; m_busy = 0; m_cause = 0; m_prev_src = '0;
      return;
    end
`ifdef IRQ_CTRL_EDGE_EN
    ev = irq_src_i & ~m_prev_src;
`else
    ev = irq_src_i;
`endif
    nxt_pend = m_pend;
    if (m_busy && irq_ret_i) nxt_pend[m_cause] = 1'b0;
    nxt_pend = nxt_pend | ev;
    if (!m_busy) begin
      pick = lowest(m_pend & m_mask);
      if (pick >= 0) begin m_busy = 1; m_cause = pick; end
    end else if (irq_ret_i) begin
      m_busy = 0;
    end
    m_pend = nxt_pend;
    if (mask_we_i) m_mask = mask_wd_i;
    m_prev_src = irq_src_i;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check("model_req", 32'(irq_req_o), 32'(m_busy));
    check("model_pend", 32'(pending_o), 32'(m_pend));
    check("model_mask", 32'(mask_o), 32'(m_mask));
    if (m_busy) check("model_cause", 32'(irq_cause_o), 32'(m_cause));
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    mask_we_i = 1'b1; mask_wd_i = m;
    cyc();
    mask_we_i = 1'b0;
  endtask

  task automatic ret_pulse();
    irq_ret_i = 1'b1;
    cyc();
    irq_ret_i = 1'b0;
  endtask

  int rises;
  logic prev_req;
  int exp_rises;

  initial begin
    // Reset
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    check("rst_req", 32'(irq_req_o), 32'd0);
    check("rst_cause", 32'(irq_cause_o), 32'd0);
    check("rst_pend", 32'(pending_o), 32'd0);
    check("rst_mask", 32'(mask_o), 32'd0);

    // Single source 0, two-cycle latency
    write_mask(16'h0001);
    irq_src_i = 16'h0001; cyc(); irq_src_i = '0;
    check("s1_req_k", 32'(irq_req_o), 32'd0);
    cyc();
    check("s1_req_k1", 32'(irq_req_o), 32'd1);
    check("s1_cause", 32'(irq_cause_o), 32'd0);
    ret_pulse();
    check("s1_req_ret", 32'(irq_req_o), 32'd0);
    check("s1_pend_ret", 32'(pending_o), 32'd0);

    // Masked source still pends; unmasking raises request
    write_mask(16'h0000);
    irq_src_i = 16'h0008; cyc(); irq_src_i = '0; cyc();
    check("s2_pend", 32'(pending_o), 32'h8);
    check("s2_req_masked", 32'(irq_req_o), 32'd0);
    write_mask(16'h0008);
    check("s2_req_w", 32'(irq_req_o), 32'd0);
    cyc();
    check("s2_req_w1", 32'(irq_req_o), 32'd1);
    check("s2_cause", 32'(irq_cause_o), 32'd3);
    ret_pulse();

    // Simultaneous sources 5 and 2: lowest first, guard cycle between
    write_mask(16'hFFFF);
    irq_src_i = 16'h0024; cyc(); irq_src_i = '0; cyc();
    check("s3_cause_a", 32'(irq_cause_o), 32'd2);
    ret_pulse();
    check("s3_guard", 32'(irq_req_o), 32'd0);
    cyc();
    check("s3_req_b", 32'(irq_req_o), 32'd1);
    check("s3_cause_b", 32'(irq_cause_o), 32'd5);

    // No preemption by higher priority arrival
    irq_src_i = 16'h0002; cyc(); irq_src_i = '0;
    cyc(); cyc();
    check("s4_hold_cause", 32'(irq_cause_o), 32'd5);
    check("s4_hold_pend", 32'(pending_o), 32'h22);
    ret_pulse();
    check("s4_guard", 32'(irq_req_o), 32'd0);
    cyc();
    check("s4_cause_next", 32'(irq_cause_o), 32'd1);
    ret_pulse();
    cyc();
    check("s4_pend_empty", 32'(pending_o), 32'd0);

    // Source 4 held high 20 cycles, serviced once
    rises = 0; prev_req = irq_req_o;
    irq_src_i = 16'h0010;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) begin
        check("s5_cause", 32'(irq_cause_o), 32'd4);
        irq_ret_i = 1'b1;
      end
      cyc();
      irq_ret_i = 1'b0;
      if (irq_req_o && !prev_req) rises++;
      prev_req = irq_req_o;
    end
    irq_src_i = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (irq_req_o && !prev_req) rises++;
      prev_req = irq_req_o;
    end
`ifdef IRQ_CTRL_EDGE_EN
    exp_rises = 1;
`else
    exp_rises = 2;
`endif
    check("s5_rises", 32'(rises), 32'(exp_rises));
    if (irq_req_o) ret_pulse();
    cyc();
    check("s5_pend_empty", 32'(pending_o), 32'd0);

    // Reset mid-service
    irq_src_i = 16'h0001; cyc(); irq_src_i = '0; cyc();
    check("s6_active", 32'(irq_req_o), 32'd1);
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    check("s6_req", 32'(irq_req_o), 32'd0);
    check("s6_pend", 32'(pending_o), 32'd0);
    check("s6_mask", 32'(mask_o), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      irq_src_i = ($urandom_range(0, 3) == 0) ? N'($urandom) & N'($urandom) : '0;
      irq_ret_i = ($urandom_range(0, 2) == 0);
      mask_we_i = ($urandom_range(0, 15) == 0);
      mask_wd_i = N'($urandom);
      rst_i     = ($urandom_range(0, 99) == 0);
      cyc();
    end
    irq_src_i = '0; irq_ret_i = 1'b0; mask_we_i = 1'b0; rst_i = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
